mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage RV32I core: consumes the EX_MEM register outputs and produces the values captured by MEM_WB.
//  Non-memory instructions pass straight through. Loads and stores run byte-serially over the 8-bit single-port RAM bus.
//  The stage holds EX_MEM and everything upstream via stall_out until the access finishes.
// PARAMETERS
//  ADDR_W  17  RAM byte-address width (128 KiB); addresses wrap mod 2^ADDR_W
// PORTS
//  clk_in        in   1       clock, posedge
//  rst_in        in   1       reset, asynchronous, active-low
//  rdE_in        in   1       rd write enable from EX_MEM
//  rdIdx_in      in   5       rd index from EX_MEM
//  rdData_in     in   32      ALU result; effective address when memE_in=1
//  memE_in       in   1       instruction is a load/store
//  memWE_in      in   1       1=store, 0=load (valid when memE_in=1)
//  funct3_in     in   3       width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  stData_in     in   32      store data (rs2)
//  ram_din_in    in   8       RAM read byte; valid 1 cycle after its address
//  ram_a_out     out  ADDR_W  RAM byte address
//  ram_wr_out    out  1       RAM write strobe
//  ram_dout_out  out  8       RAM write byte
//  stall_out     out  1       hold EX_MEM and upstream stages
//  rdE_out       out  1       to MEM_WB
//  rdIdx_out     out  5       to MEM_WB
//  rdData_out    out  32      to MEM_WB
// BEHAVIOUR
//  - States: IDLE, LOAD, STORE, DONE.
//  - Reset: while rst_in=0, force state IDLE and all counters to 0. All outputs are 0 during reset.
//  - Reset mid-access aborts immediately. ram_wr_out drops asynchronously. Bytes already written stay in RAM.
//  - N (byte count) = 1 for funct3[1:0]=00, 2 for 01, 4 otherwise. Unlisted funct3 codes are treated as W.
//  - Byte order is little-endian: byte k is at address addr+k.
//  - IDLE, memE_in=0:
//    - rd*_out = rd*_in combinationally; stall_out=0; ram_wr_out=0.
//  - IDLE, memE_in=1:
//    - Latch addr, funct3, stData, rdIdx. stall_out=1 combinationally.
//    - Load: ram_a_out=addr; next state LOAD, issue=1, recv=0.
//    - Store: ram_a_out=addr, ram_wr_out=1, ram_dout_out=stData[7:0]. Next state DONE if N=1, else STORE with cnt=1.
//  - LOAD, each cycle:
//    - Capture ram_din_in into byte[recv]; recv++.
//    - If issue<N: ram_a_out=addr+issue and issue++.
//    - After byte N-1 is captured, go to DONE.
//  - STORE, each cycle:
//    - ram_a_out=addr+cnt; ram_wr_out=1; ram_dout_out=stData byte cnt.
//    - After cnt=N-1, go to DONE.
//  - DONE:
//    - stall_out=0. MEM_WB captures at this edge and EX_MEM advances. Always return to IDLE.
//    - Load: rdE_out=1, rdIdx_out=latched rdIdx, rdData_out=assembled value (sign-extended for B/H, zero-extended for BU/HU).
//    - Store: rdE_out=0, rdIdx_out=0, rdData_out=0.
//  - In LOAD/STORE, rd*_out=0. Inputs are ignored while busy (held by stall).
//  - Latency: load = N+2 cycles (stall N+1); store = N+1 cycles (stall N).
//  - Back-to-back: a new mem op in the cycle after DONE starts from IDLE with no bubble beyond DONE.
//  - ram_a_out=0 and ram_dout_out=0 whenever no address or write is being driven.
// CONFIGURATION
//  MEM_FORWARD_EN defined:
//    - Adds fwd_rdE_out, fwd_rdIdx_out and fwd_rdData_out, mirroring rd*_out, for the ID-stage bypass.
//    - fwd_rdE_out=0 while stall_out=1.
//  MEM_FORWARD_EN undefined:
//    - These ports are absent. ID resolves hazards only through MEM_WB/WB.
// STRUCTURE
//  - defines.vh: dataRange, regIdxRange, funct3 load/store codes, state encodings, writeDisable/regNOP/ZERO32.
//  - Sub-module mem_load_ext (combinational): 4 bytes + funct3 -> sign/zero-extended 32-bit word.
//  - The byte-select mux for stores stays inline.
// TESTING
//  - ALU op: memE=0, rdE=1, rdIdx=5, rdData=0x1234 -> same values on outputs that cycle, stall_out=0.
//  - LW at 0x100, RAM bytes 78 56 34 12 -> ram_a 0x100..0x103 on cycles 0..3; stall high cycles 0-4; DONE cycle 5 with rdData=0x12345678.
//  - LB at 0x3, byte 0x80 -> 0xFFFFFF80. LBU at 0x3 -> 0x00000080. LHU at 0x4, bytes FF 80 -> 0x000080FF.
//  - SH at 0x1FFFF, data 0xAABBCCDD -> writes DD at 0x1FFFF and CC at 0x00000 (wrap); DONE has rdE_out=0.
//  - SW issued; rst_in pulled low in cycle 2 -> ram_wr_out=0 at once; bytes 0-1 written, 2-3 not; outputs 0.
//  - SW then LW to the same address back-to-back -> LW returns the stored word; no extra idle cycle between the ops.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM stage.
//   mem_state_e  - MEM-stage sequencer states
//   F3_*         - RV32I load/store funct3 width/sign codes
//   ZERO32/REG_NOP - idle values driven towards MEM_WB
//   byte_count() - number of RAM bytes moved for a given funct3
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_e;

  localparam logic [2:0]  F3_B    = 3'b000;
  localparam logic [2:0]  F3_H    = 3'b001;
  localparam logic [2:0]  F3_W    = 3'b010;
  localparam logic [2:0]  F3_BU   = 3'b100;
  localparam logic [2:0]  F3_HU   = 3'b101;
  localparam logic [31:0] ZERO32  = 32'h0000_0000;
  localparam logic [4:0]  REG_NOP = 5'd0;

  // Width comes from funct3[1:0]; any code that is not B/H moves a full word.
  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   byte_count = 3'd1;
      2'b01:   byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load-result extension.
//   bytes_in  [31:0] - assembled little-endian load bytes (byte 0 in [7:0])
//   funct3_in [2:0]  - load width/sign code
//   word_out  [31:0] - sign-extended (B/H), zero-extended (BU/HU) or full word
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] bytes_in,
  input  logic [2:0]  funct3_in,
  output logic [31:0] word_out
);

  // Select extension by funct3; unlisted codes behave as a plain word load.
  always_comb begin
    word_out = ZERO32;
    case (funct3_in)
      F3_B:    word_out = {{24{bytes_in[7]}}, bytes_in[7:0]};
      F3_H:    word_out = {{16{bytes_in[15]}}, bytes_in[15:0]};
      F3_BU:   word_out = {24'h00_0000, bytes_in[7:0]};
      F3_HU:   word_out = {16'h0000, bytes_in[15:0]};
      default: word_out = bytes_in;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the RV32I pipeline with a byte-serial 8-bit RAM port.
//   clk_in, rst_in (async, active-low)
//   rdE_in/rdIdx_in/rdData_in, memE_in, memWE_in, funct3_in, stData_in - from EX_MEM
//   ram_din_in (read byte, one cycle after its address)
//   ram_a_out/ram_wr_out/ram_dout_out - RAM address, write strobe, write byte
//   stall_out - holds EX_MEM and upstream while an access is in flight
//   rdE_out/rdIdx_out/rdData_out - values captured by MEM_WB
// Optional feature macro MEM_FORWARD_EN: adds fwd_rdE_out/fwd_rdIdx_out/
// fwd_rdData_out mirroring rd*_out for the ID-stage bypass (rdE gated by stall).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdE_in,
  input  logic [4:0]        rdIdx_in,
  input  logic [31:0]       rdData_in,
  input  logic              memE_in,
  input  logic              memWE_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       stData_in,
  input  logic [7:0]        ram_din_in,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  output logic [7:0]        ram_dout_out,
  output logic              stall_out,
  output logic              rdE_out,
  output logic [4:0]        rdIdx_out,
  output logic [31:0]       rdData_out
`ifdef MEM_FORWARD_EN
  ,
  output logic              fwd_rdE_out,
  output logic [4:0]        fwd_rdIdx_out,
  output logic [31:0]       fwd_rdData_out
`endif
);

  mem_state_e        state_r, state_s;
  logic [2:0]        issue_r, issue_s;   // next byte to address (load) / write (store)
  logic [1:0]        recv_r, recv_s;     // next load byte slot to capture
  logic [3:0][7:0]   bytes_r, bytes_s;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        funct3_r;
  logic [3:0][7:0]   st_data_r;
  logic [4:0]        rd_idx_r;
  logic              store_r;
  logic              latch_s;
  logic [2:0]        n_s, n_in_s;
  logic [31:0]       ext_word_s;

  logic [ADDR_W-1:0] a_s;
  logic              wr_s;
  logic [7:0]        dout_s;
  logic              stall_s;
  logic              rde_s;
  logic [4:0]        rdidx_s;
  logic [31:0]       rddata_s;

  assign n_s    = byte_count(funct3_r);
  assign n_in_s = byte_count(funct3_in);

  mem_load_ext u_load_ext (
    .bytes_in  (bytes_r),
    .funct3_in (funct3_r),
    .word_out  (ext_word_s)
  );

  // Sequencer next-state, counters and raw (pre-reset-gating) outputs.
  always_comb begin
    state_s  = state_r;
    issue_s  = issue_r;
    recv_s   = recv_r;
    bytes_s  = bytes_r;
    latch_s  = 1'b0;
    a_s      = {ADDR_W{1'b0}};
    wr_s     = 1'b0;
    dout_s   = 8'h00;
    stall_s  = 1'b0;
    rde_s    = 1'b0;
    rdidx_s  = REG_NOP;
    rddata_s = ZERO32;
    case (state_r)
      ST_IDLE: begin
        if (memE_in) begin
          // Byte 0 goes out in this same cycle, so latency starts here.
          latch_s = 1'b1;
          stall_s = 1'b1;
          a_s     = rdData_in[ADDR_W-1:0];
          issue_s = 3'd1;
          recv_s  = 2'd0;
          if (memWE_in) begin
            wr_s    = 1'b1;
            dout_s  = stData_in[7:0];
            state_s = (n_in_s == 3'd1) ? ST_DONE : ST_STORE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          rde_s    = rdE_in;
          rdidx_s  = rdIdx_in;
          rddata_s = rdData_in;
        end
      end
      ST_LOAD: begin
        // Each cycle returns the byte addressed in the previous cycle.
        stall_s          = 1'b1;
        bytes_s[recv_r]  = ram_din_in;
        recv_s           = recv_r + 2'd1;
        if (issue_r < n_s) begin
          a_s     = addr_r + ADDR_W'(issue_r);
          issue_s = issue_r + 3'd1;
        end else begin
          issue_s = issue_r;
        end
        if ({1'b0, recv_r} == (n_s - 3'd1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_STORE: begin
        stall_s = 1'b1;
        wr_s    = 1'b1;
        a_s     = addr_r + ADDR_W'(issue_r);
        case (issue_r[1:0])
          2'd0:    dout_s = st_data_r[0];
          2'd1:    dout_s = st_data_r[1];
          2'd2:    dout_s = st_data_r[2];
          default: dout_s = st_data_r[3];
        endcase
        if (issue_r == (n_s - 3'd1)) begin
          state_s = ST_DONE;
          issue_s = 3'd0;
        end else begin
          state_s = ST_STORE;
          issue_s = issue_r + 3'd1;
        end
      end
      ST_DONE: begin
        // Stall drops so MEM_WB captures the result and EX_MEM advances.
        state_s = ST_IDLE;
        issue_s = 3'd0;
        recv_s  = 2'd0;
        if (store_r) begin
          rde_s    = 1'b0;
          rdidx_s  = REG_NOP;
          rddata_s = ZERO32;
        end else begin
          rde_s    = 1'b1;
          rdidx_s  = rd_idx_r;
          rddata_s = ext_word_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and the latched request.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r   <= ST_IDLE;
      issue_r   <= 3'd0;
      recv_r    <= 2'd0;
      bytes_r   <= 32'h0000_0000;
      addr_r    <= {ADDR_W{1'b0}};
      funct3_r  <= 3'd0;
      st_data_r <= 32'h0000_0000;
      rd_idx_r  <= 5'd0;
      store_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      issue_r <= issue_s;
      recv_r  <= recv_s;
      bytes_r <= bytes_s;
      if (latch_s) begin
        addr_r    <= rdData_in[ADDR_W-1:0];
        funct3_r  <= funct3_in;
        st_data_r <= stData_in;
        rd_idx_r  <= rdIdx_in;
        store_r   <= memWE_in;
      end
    end
  end

  // Outputs are forced low while reset is held, so a write in flight stops at once.
  always_comb begin
    if (rst_in) begin
      ram_a_out    = a_s;
      ram_wr_out   = wr_s;
      ram_dout_out = dout_s;
      stall_out    = stall_s;
      rdE_out      = rde_s;
      rdIdx_out    = rdidx_s;
      rdData_out   = rddata_s;
    end else begin
      ram_a_out    = {ADDR_W{1'b0}};
      ram_wr_out   = 1'b0;
      ram_dout_out = 8'h00;
      stall_out    = 1'b0;
      rdE_out      = 1'b0;
      rdIdx_out    = REG_NOP;
      rdData_out   = ZERO32;
    end
  end

`ifdef MEM_FORWARD_EN
  // ID-stage bypass copy; never advertise a write while the stage is stalled.
  always_comb begin
    fwd_rdE_out    = rdE_out & ~stall_out;
    fwd_rdIdx_out  = rdIdx_out;
    fwd_rdData_out = rdData_out;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed + randomized bench for mem_stage with an in-bench
// byte RAM and a reference memory image used to predict load results.
module tb_mem_stage;

  localparam int ADDR_W = 17;
  localparam int RAM_SZ = 1 << ADDR_W;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdE_in;
  logic [4:0]        rdIdx_in;
  logic [31:0]       rdData_in;
  logic              memE_in;
  logic              memWE_in;
  logic [2:0]        funct3_in;
  logic [31:0]       stData_in;
  logic [7:0]        ram_din_in;
  logic [ADDR_W-1:0] ram_a_out;
  logic              ram_wr_out;
  logic [7:0]        ram_dout_out;
  logic              stall_out;
  logic              rdE_out;
  logic [4:0]        rdIdx_out;
  logic [31:0]       rdData_out;
`ifdef MEM_FORWARD_EN
  logic              fwd_rdE_out;
  logic [4:0]        fwd_rdIdx_out;
  logic [31:0]       fwd_rdData_out;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] ram     [0:RAM_SZ-1] = '{default: 8'h00};
  logic [7:0] ref_mem [0:RAM_SZ-1] = '{default: 8'h00};

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdE_in       (rdE_in),
    .rdIdx_in     (rdIdx_in),
    .rdData_in    (rdData_in),
    .memE_in      (memE_in),
    .memWE_in     (memWE_in),
    .funct3_in    (funct3_in),
    .stData_in    (stData_in),
    .ram_din_in   (ram_din_in),
    .ram_a_out    (ram_a_out),
    .ram_wr_out   (ram_wr_out),
    .ram_dout_out (ram_dout_out),
    .stall_out    (stall_out),
    .rdE_out      (rdE_out),
    .rdIdx_out    (rdIdx_out),
    .rdData_out   (rdData_out)
`ifdef MEM_FORWARD_EN
    ,
    .fwd_rdE_out    (fwd_rdE_out),
    .fwd_rdIdx_out  (fwd_rdIdx_out),
    .fwd_rdData_out (fwd_rdData_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Single-port RAM: synchronous write, read data one cycle after the address.
  always @(posedge clk_in) begin
    if (ram_wr_out) ram[ram_a_out] <= ram_dout_out;
    ram_din_in <= ram[ram_a_out];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a, input int k);
    return a + ADDR_W'(k);
  endfunction

  // Reference load value: little-endian sum of bytes, then two's-complement fix for signed B/H.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [ADDR_W-1:0] a);
    longint v;
    int     n;
    n = nbytes(f3);
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(ref_mem[wrap(a, k)]) << (8 * k);
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic drive(input bit mem, input bit we, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] sd, input logic rde, input logic [4:0] idx);
    memE_in   = mem;
    memWE_in  = we;
    funct3_in = f3;
    rdData_in = ad;
    stData_in = sd;
    rdE_in    = rde;
    rdIdx_in  = idx;
  endtask

  // Runs one EX_MEM instruction; called #1 after a posedge, returns #1 after the edge that ends it.
  task automatic run_op(input bit mem, input bit we, input logic [2:0] f3, input logic [31:0] ad,
                        input logic [31:0] sd, input logic rde, input logic [4:0] idx,
                        output logic [31:0] obs);
    int                n;
    logic [ADDR_W-1:0] a;
    logic [31:0]       exp_v;
    drive(mem, we, f3, ad, sd, rde, idx);
    n = nbytes(f3);
    a = ad[ADDR_W-1:0];
    if (!mem) begin
      @(negedge clk_in);
      chk("alu_stall", {31'd0, stall_out}, 32'd0);
      chk("alu_rdE", {31'd0, rdE_out}, {31'd0, rde});
      chk("alu_rdIdx", {27'd0, rdIdx_out}, {27'd0, idx});
      chk("alu_rdData", rdData_out, ad);
      chk("alu_wr", {31'd0, ram_wr_out}, 32'd0);
      obs = rdData_out;
      @(posedge clk_in); #1;
    end else if (we) begin
      for (int k = 0; k < n; k++) begin
        @(negedge clk_in);
        chk("st_stall", {31'd0, stall_out}, 32'd1);
        chk("st_wr", {31'd0, ram_wr_out}, 32'd1);
        chk("st_addr", 32'(ram_a_out), 32'(wrap(a, k)));
        chk("st_dout", {24'd0, ram_dout_out}, (sd >> (8 * k)) & 32'hFF);
        chk("st_busy_rdE", {31'd0, rdE_out}, 32'd0);
        ref_mem[wrap(a, k)] = 8'((sd >> (8 * k)) & 32'hFF);
        @(posedge clk_in); #1;
      end
      @(negedge clk_in);
      chk("st_done_stall", {31'd0, stall_out}, 32'd0);
      chk("st_done_wr", {31'd0, ram_wr_out}, 32'd0);
      chk("st_done_rdE", {31'd0, rdE_out}, 32'd0);
      chk("st_done_rdIdx", {27'd0, rdIdx_out}, 32'd0);
      chk("st_done_rdData", rdData_out, 32'd0);
      obs = rdData_out;
      @(posedge clk_in); #1;
    end else begin
      exp_v = load_model(f3, a);
      for (int k = 0; k <= n; k++) begin
        @(negedge clk_in);
        chk("ld_stall", {31'd0, stall_out}, 32'd1);
        chk("ld_wr", {31'd0, ram_wr_out}, 32'd0);
        chk("ld_addr", 32'(ram_a_out), (k < n) ? 32'(wrap(a, k)) : 32'd0);
        chk("ld_busy_rdE", {31'd0, rdE_out}, 32'd0);
        @(posedge clk_in); #1;
      end
      @(negedge clk_in);
      chk("ld_done_stall", {31'd0, stall_out}, 32'd0);
      chk("ld_done_rdE", {31'd0, rdE_out}, 32'd1);
      chk("ld_done_rdIdx", {27'd0, rdIdx_out}, {27'd0, idx});
      chk("ld_done_rdData", rdData_out, exp_v);
      obs = rdData_out;
      @(posedge clk_in); #1;
    end
  endtask

  initial begin
    logic [31:0]       obs;
    logic [ADDR_W-1:0] ra;
    logic [7:0]        old2, old3;
    bit                mem, we;
    logic [31:0]       ad;

    // Reset: outputs forced to zero even with a live ALU op on the inputs.
    rst_in = 1'b0;
    drive(1'b0, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd7);
    @(negedge clk_in);
    chk("rst_rdE", {31'd0, rdE_out}, 32'd0);
    chk("rst_rdData", rdData_out, 32'd0);
    chk("rst_rdIdx", {27'd0, rdIdx_out}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_addr", 32'(ram_a_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    run_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1, 5'd5, obs);

    // SW then LW back-to-back; LW expected at the very next cycle.
    run_op(1'b1, 1'b1, 3'b010, 32'h100, 32'h1234_5678, 1'b0, 5'd0, obs);
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5'd9, obs);
    chk("lw_value", obs, 32'h1234_5678);
    chk("lw_ram_byte3", {24'd0, ram[17'h103]}, 32'h12);

    run_op(1'b1, 1'b1, 3'b000, 32'h3, 32'h0000_0080, 1'b0, 5'd0, obs);
    run_op(1'b1, 1'b0, 3'b000, 32'h3, 32'h0, 1'b1, 5'd10, obs);
    chk("lb_value", obs, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 1'b1, 5'd11, obs);
    chk("lbu_value", obs, 32'h0000_0080);

    run_op(1'b1, 1'b1, 3'b001, 32'h4, 32'h0000_80FF, 1'b0, 5'd0, obs);
    run_op(1'b1, 1'b0, 3'b101, 32'h4, 32'h0, 1'b1, 5'd12, obs);
    chk("lhu_value", obs, 32'h0000_80FF);
    run_op(1'b1, 1'b0, 3'b001, 32'h4, 32'h0, 1'b1, 5'd13, obs);
    chk("lh_value", obs, 32'hFFFF_80FF);

    // Halfword store across the top of the address space wraps to 0.
    run_op(1'b1, 1'b1, 3'b001, 32'h1_FFFF, 32'hAABB_CCDD, 1'b0, 5'd3, obs);
    chk("sh_wrap_hi", {24'd0, ram[17'h1_FFFF]}, 32'hDD);
    chk("sh_wrap_lo", {24'd0, ram[17'h0_0000]}, 32'hCC);
    run_op(1'b1, 1'b0, 3'b010, 32'h1_FFFE, 32'h0, 1'b1, 5'd14, obs);

    // Reset in the third cycle of a SW: write stops at once, first two bytes stay.
    ra   = 17'h40;
    old2 = ref_mem[ra + 17'd2];
    old3 = ref_mem[ra + 17'd3];
    drive(1'b1, 1'b1, 3'b010, 32'(ra), 32'hCAFE_F00D, 1'b0, 5'd0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    chk("rst_mid_wr", {31'd0, ram_wr_out}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_mid_addr", 32'(ram_a_out), 32'd0);
    chk("rst_mid_dout", {24'd0, ram_dout_out}, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    chk("rst_mid_b0", {24'd0, ram[ra]}, 32'h0D);
    chk("rst_mid_b1", {24'd0, ram[ra + 17'd1]}, 32'hF0);
    chk("rst_mid_b2", {24'd0, ram[ra + 17'd2]}, {24'd0, old2});
    chk("rst_mid_b3", {24'd0, ram[ra + 17'd3]}, {24'd0, old3});
    ref_mem[ra]         = 8'h0D;
    ref_mem[ra + 17'd1] = 8'hF0;
    rst_in = 1'b1;
    run_op(1'b1, 1'b0, 3'b010, 32'(ra), 32'h0, 1'b1, 5'd15, obs);

    // Random mix over two small windows so loads hit earlier stores and wrap.
    for (int i = 0; i < 80; i++) begin
      mem = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) == 1;
      ad  = $urandom_range(0, 1) == 1 ? 32'(17'h1_FFF8 + 17'($urandom_range(0, 7)))
                                      : 32'($urandom_range(0, 31));
      if (!mem) ad = $urandom;
      run_op(mem, we, 3'($urandom_range(0, 7)), ad, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), obs);
    end

    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    @(posedge clk_in); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
